// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a byte FIFO, programmable bit divider and frame format.
// Divider and format are copied into frame-local registers at pop time, so register writes only affect later frames.
package uart_tx_fifo_pkg;
   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [7:0]  mem_wstrb;
      logic [63:0] mem_wdata;
   } mem_in_type;
   typedef struct packed {
      logic [63:0] mem_rdata;
      logic        mem_error;
      logic        mem_ready;
   } mem_out_type;
endpackage

module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int clock_rate = 868,
   parameter int fifo_depth = 16
) (
   input  logic        reset,
   input  logic        clock,
   input  mem_in_type  uart_in,
   output mem_out_type uart_out,
   output logic        tx_irq,
   output logic        tx
);
   localparam int aw = $clog2(fifo_depth);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic [7:0] fifo_mem [fifo_depth];
   logic [aw-1:0] wr_ptr, rd_ptr;
   logic [8:0] count;
   logic [31:0] div, f_div, cnt;
   logic parity_en, parity_odd, two_stop, irq_en;
   logic [7:0] watermark, shift;
   logic f_parity_en, f_two_stop, f_parity;
   logic [2:0] bit_idx;
   state_t state, state_next;
   logic wr, sel_data, sel_status, sel_div, sel_ctrl, full, empty, push, pop, bit_end, err;
   logic [63:0] status, rdata;
   logic unused_bits;

   assign unused_bits = ^uart_in.mem_wdata[63:32];

   always_comb begin
      wr = |uart_in.mem_wstrb;
      sel_data = uart_in.mem_addr == 32'd0;
      sel_status = uart_in.mem_addr == 32'd8;
      sel_div = uart_in.mem_addr == 32'd16;
      sel_ctrl = uart_in.mem_addr == 32'd24;
      full = count == 9'(fifo_depth);
      empty = count == 9'd0;
      status = {47'd0, count, 5'd0, state != IDLE, full, empty};
      err = uart_in.mem_valid & (sel_data ? (!wr | full) : sel_status ? wr : !(sel_div | sel_ctrl));
      push = uart_in.mem_valid & wr & sel_data & !full;
      rdata = (!uart_in.mem_valid | wr | err) ? 64'd0 : sel_status ? status : sel_div ? {32'd0, div} :
              {48'd0, watermark, 4'd0, irq_en, two_stop, parity_odd, parity_en};
   end

   // bit_idx counts data bits in DATA and stop bits in STOP; it clears on every state change
   always_comb begin
      state_next = state;
      pop = 1'b0;
      bit_end = cnt == f_div;
      case (state)
         IDLE: begin
            state_next = empty ? IDLE : START;
            pop = !empty;
         end
         START: state_next = bit_end ? DATA : START;
         DATA: state_next = (bit_end && bit_idx == 3'd7) ? (f_parity_en ? PARITY : STOP) : DATA;
         PARITY: state_next = bit_end ? STOP : PARITY;
         STOP: state_next = (bit_end && (bit_idx[0] || !f_two_stop)) ? IDLE : STOP;
         default: state_next = IDLE;
      endcase
      tx = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? f_parity : 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= 32'd0;
         bit_idx <= 3'd0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= 9'd0;
         div <= 32'(clock_rate);
         parity_en <= 1'b0;
         parity_odd <= 1'b0;
         two_stop <= 1'b0;
         irq_en <= 1'b0;
         watermark <= 8'd0;
         tx_irq <= 1'b0;
         uart_out <= '0;
      end else begin
         state <= state_next;
         cnt <= (state == IDLE || bit_end) ? 32'd0 : cnt + 32'd1;
         bit_idx <= state != state_next ? 3'd0 : bit_idx + 3'(bit_end);
         wr_ptr <= wr_ptr + aw'(push);
         rd_ptr <= rd_ptr + aw'(pop);
         count <= count + 9'(push) - 9'(pop);
         if (uart_in.mem_valid && wr && sel_div)
            div <= uart_in.mem_wdata[31:0];
         if (uart_in.mem_valid && wr && sel_ctrl) begin
            parity_en <= uart_in.mem_wdata[0];
            parity_odd <= uart_in.mem_wdata[1];
            two_stop <= uart_in.mem_wdata[2];
            irq_en <= uart_in.mem_wdata[3];
            watermark <= uart_in.mem_wdata[15:8];
         end
         tx_irq <= irq_en & (count <= {1'b0, watermark});
         uart_out.mem_ready <= uart_in.mem_valid;
         uart_out.mem_error <= err;
         uart_out.mem_rdata <= rdata;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr] <= uart_in.mem_wdata[7:0];
      if (pop) begin
         shift <= fifo_mem[rd_ptr];
         f_div <= div;
         f_parity_en <= parity_en;
         f_two_stop <= two_stop;
         f_parity <= ^fifo_mem[rd_ptr] ^ parity_odd;
      end else if (state == DATA && bit_end)
         shift <= shift >> 1;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; bus responses and serial frames are predicted at issue time and checked by monitors.
module tb_uart_tx_fifo;
   import uart_tx_fifo_pkg::*;
   localparam int depth = 16;
   localparam int rate = 868;
   logic clock = 1'b0;
   logic reset = 1'b0;
   mem_in_type uart_in;
   mem_out_type uart_out;
   logic tx_irq, tx;

   uart_tx_fifo #(.clock_rate(rate), .fifo_depth(depth)) dut (
      .reset(reset), .clock(clock), .uart_in(uart_in), .uart_out(uart_out), .tx_irq(tx_irq), .tx(tx));

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] d;
      int div;
      logic pen, podd, two;
   } frame_t;
   typedef bit bits_t[$];

   frame_t exp_frames[$];
   logic [64:0] exp_rsp[$];
   int checks = 0;
   int failures = 0;
   int cur_div = rate;
   logic [15:0] cur_ctrl = 16'd0;
   bit in_frame = 1'b0;
   int pos = 0;
   int bad = 0;
   int gap = 0;
   int gaps[$];
   bits_t wave;
   frame_t cur;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Line levels of a whole frame, one entry per clock cycle
   function automatic bits_t make_wave(input frame_t f);
      bits_t b;
      bit lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(f.d[i]);
      if (f.pen) lv.push_back((^f.d) ^ f.podd);
      lv.push_back(1'b1);
      if (f.two) lv.push_back(1'b1);
      foreach (lv[i]) repeat (f.div + 1) b.push_back(lv[i]);
      return b;
   endfunction

   always @(negedge clock) begin
      logic [64:0] r;
      if (uart_out.mem_ready) begin
         if (exp_rsp.size() == 0) check("unexpected mem_ready", 1, 0);
         else begin
            r = exp_rsp.pop_front();
            check("mem_rdata", uart_out.mem_rdata, r[64:1]);
            check("mem_error", 64'(uart_out.mem_error), 64'(r[0]));
         end
      end else
         check("idle response", uart_out.mem_rdata | 64'(uart_out.mem_error), 0);
   end

   always @(negedge clock) begin
      if (!reset) begin
         in_frame = 1'b0;
         exp_frames.delete();
         gap = 0;
      end else if (in_frame) begin
         if (tx !== wave[pos]) bad++;
         pos++;
         if (pos == wave.size()) begin
            check($sformatf("frame %h bad samples", cur.d), bad, 0);
            in_frame = 1'b0;
            gap = 0;
         end
      end else if (tx === 1'b0) begin
         if (exp_frames.size() == 0) check("unexpected start bit", 1, 0);
         else begin
            cur = exp_frames.pop_front();
            wave = make_wave(cur);
            gaps.push_back(gap);
            bad = 0;
            pos = 1;
            in_frame = 1'b1;
         end
      end else gap++;
   end

   task automatic bus(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                      input logic [63:0] er, input logic ee);
      exp_rsp.push_back({er, ee});
      uart_in.mem_valid = 1'b1;
      uart_in.mem_addr = a;
      uart_in.mem_wstrb = s;
      uart_in.mem_wdata = d;
      @(posedge clock);
      #1;
      uart_in = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic ee);
      bus(a, 8'hff, d, 64'd0, ee);
   endtask

   task automatic rd(input logic [31:0] a, input logic [63:0] er, input logic ee);
      bus(a, 8'h00, {$urandom, $urandom}, er, ee);
   endtask

   task automatic push(input logic [7:0] b);
      frame_t f;
      f.d = b;
      f.div = cur_div;
      f.pen = cur_ctrl[0];
      f.podd = cur_ctrl[1];
      f.two = cur_ctrl[2];
      exp_frames.push_back(f);
      wr(32'd0, {$urandom, $urandom(), 24'd0, b} & {56'hffffffff_ffffff, 8'hff}, 1'b0);
   endtask

   task automatic set_cfg(input int dv, input logic [15:0] c);
      wr(32'd16, {$urandom, 32'(dv)}, 1'b0);
      wr(32'd24, {48'd0, c}, 1'b0);
      cur_div = dv;
      cur_ctrl = c & 16'hff0f;
      rd(32'd16, 64'(dv), 1'b0);
      rd(32'd24, 64'(cur_ctrl), 1'b0);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 30000; i++) begin
         @(negedge clock);
         if (exp_frames.size() == 0 && !in_frame) break;
      end
      if (i == 30000) check("drain timeout", 1, 0);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("reset tx", 64'(tx), 1);
      check("reset tx_irq", 64'(tx_irq), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      cur_div = rate;
      cur_ctrl = 16'd0;
      rd(32'd8, 64'h1, 1'b0);
      rd(32'd16, 64'(rate), 1'b0);
      rd(32'd24, 64'd0, 1'b0);
   endtask

   task automatic bad_access();
      case ($urandom_range(0, 2))
         0: rd(32'd40 + 32'($urandom_range(0, 20)), 64'd0, 1'b1);
         1: rd(32'd0, 64'd0, 1'b1);
         default: wr(32'd8, {$urandom, $urandom}, 1'b1);
      endcase
   endtask

   initial begin
      int k;
      uart_in = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("power-on tx", 64'(tx), 1);
      check("power-on tx_irq", 64'(tx_irq), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      rd(32'd8, 64'h1, 1'b0);
      rd(32'd16, 64'(rate), 1'b0);
      rd(32'd24, 64'd0, 1'b0);
      rd(32'd40, 64'd0, 1'b1);
      rd(32'd0, 64'd0, 1'b1);
      wr(32'd8, 64'h7, 1'b1);
      wr(32'd4, 64'h7, 1'b1);
      rd(32'd8, 64'h1, 1'b0);

      set_cfg(3, 16'h0000);
      push(8'h55);
      drain();
      rd(32'd8, 64'h1, 1'b0);
      set_cfg(1, 16'h0005);
      push(8'h07);
      drain();
      set_cfg(1, 16'h0007);
      push(8'h07);
      drain();
      set_cfg(0, 16'h0000);
      push(8'hc4);
      drain();

      set_cfg(3, 16'h0000);
      push(8'h3c);
      repeat (5) @(posedge clock);
      #1;
      set_cfg(1, 16'h0003);
      push(8'hc3);
      drain();

      set_cfg(50, 16'h0208);
      check("irq at count 0", 64'(tx_irq), 1);
      gaps.delete();
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      @(negedge clock);
      check("irq delayed one cycle", 64'(tx_irq), 1);
      @(negedge clock);
      check("irq low at count 3", 64'(tx_irq), 0);
      @(posedge clock);
      #1;
      rd(32'd8, 64'h304, 1'b0);
      for (k = 0; k < 2000; k++) begin
         @(negedge clock);
         if (tx_irq) break;
      end
      check("irq rises again", 64'(tx_irq), 1);
      @(posedge clock);
      #1;
      rd(32'd8, 64'h204, 1'b0);
      drain();
      check("frames in irq test", gaps.size(), 4);
      for (int i = 1; i < 4 && i < gaps.size(); i++) check($sformatf("back-to-back gap %0d", i), gaps[i], 1);
      set_cfg(2, 16'h0000);

      set_cfg(1000, 16'h0000);
      for (int i = 0; i <= depth; i++) push(8'($urandom));
      wr(32'd0, 64'h5a, 1'b1);
      rd(32'd8, 64'((depth << 8) | 6), 1'b0);
      repeat (20) @(posedge clock);
      #1;
      do_reset();

      set_cfg(3, 16'h0000);
      push(8'ha5);
      for (k = 0; k < 200; k++) begin
         @(negedge clock);
         if (in_frame && pos == 18) break;
      end
      check("reached data bit 3", k < 200, 1);
      @(posedge clock);
      #1;
      do_reset();

      for (int b = 0; b < 6; b++) begin
         set_cfg($urandom_range(0, 3), 16'($urandom));
         for (int i = 0; i < $urandom_range(1, depth); i++) begin
            if ($urandom_range(0, 4) == 0) bad_access();
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
         end
         drain();
         rd(32'd8, 64'h1, 1'b0);
      end

      repeat (3) @(negedge clock);
      check("responses outstanding", exp_rsp.size(), 0);
      check("frames outstanding", exp_frames.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter clock_rate, default 868, reset value of the divider register (clock cycles per bit minus 1).
REQ-002 SHALL have parameter fifo_depth, default 16, TX FIFO entries, power of 2, range 2..256.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port uart_in  input  mem_in_type  bus request: mem_valid, mem_addr, mem_wstrb, mem_wdata.
REQ-006 SHALL have port uart_out  output  mem_out_type  bus response: mem_rdata (64 bits), mem_error, mem_ready.
REQ-007 SHALL have port tx_irq  output  1  level interrupt, TX FIFO at or below watermark.
REQ-008 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-009 SHALL decode four registers by mem_addr: 0 DATA (write-only), 8 STATUS (read-only), 16 DIV (R/W, 32 bits), 24 CTRL (R/W).
REQ-010 SHALL treat a request as a write when |mem_wstrb = 1 and as a read otherwise.
REQ-011 SHALL assert mem_ready for exactly one cycle, the cycle after each mem_valid cycle; rdata and error are valid in that cycle and 0 otherwise.
REQ-012 SHALL push mem_wdata[7:0] into the FIFO on a DATA write when not full; on a DATA write when full, data is dropped and mem_error = 1.
REQ-013 SHALL set mem_error = 1 for unmapped addresses, DATA reads and STATUS writes, with no state change.
REQ-014 SHALL return STATUS = {count[8:0] in bits 16:8, bit2 busy, bit1 full, bit0 empty}, zero elsewhere.
REQ-015 SHALL define CTRL bits: 0 parity_en, 1 parity_odd, 2 two_stop, 3 irq_en, 15:8 watermark; reads return written value, other bits 0.
REQ-016 SHALL implement FSM IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: tx = 1; if FIFO not empty, pop head, latch DIV and CTRL into frame-local copies, go START.
REQ-018 Each bit SHALL last latched_div + 1 cycles; div = 0 gives 1 cycle per bit.
REQ-019 START drives 0; DATA drives 8 bits LSB first; PARITY (only if parity_en) drives XOR of data bits, inverted when parity_odd; STOP drives 1 for 1 or 2 bit times (two_stop), then IDLE.
REQ-020 DIV/CTRL writes during a frame SHALL affect only the next frame.
REQ-021 Back-to-back frames: SHALL enter START the cycle after the last stop bit ends if FIFO not empty (IDLE lasts one cycle).
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order; push while empty and idle SHALL be popped the following cycle.
REQ-023 Pointers SHALL wrap modulo fifo_depth; count ranges 0..fifo_depth.
REQ-024 tx_irq SHALL equal irq_en AND (count <= watermark), registered, one-cycle delayed from count change.
REQ-025 busy SHALL be 1 whenever state != IDLE.

Reset
REQ-026 On reset = 0 at a clock edge: state IDLE, FIFO emptied, DIV = clock_rate, CTRL = 0, tx = 1, tx_irq = 0, mem_ready = 0, mem_error = 0, mem_rdata = 0.
REQ-027 Reset mid-frame SHALL abort the frame; tx = 1 from the cycle after the reset edge.

Verification
- DIV=3, CTRL=0, write DATA 0x55 -> tx: 0, then 1,0,1,0,1,0,1,0, then 1, each 4 cycles; busy 1 for 40 cycles.
- CTRL=0x5 (parity even, 2 stop), DIV=1, write 0x07 -> parity bit 1, stop high 4 cycles; CTRL=0x7 -> parity 0.
- Write fifo_depth+1 bytes with tx stalled at DIV=1000 -> first popped; depth+1 accepted, next write gets error=1; STATUS full=1.
- Read addr 40 -> mem_ready=1, mem_error=1, rdata=0; read STATUS when empty -> 0x1.
- CTRL=0x0208 (irq_en, watermark 2), push 4 bytes -> tx_irq low at count 3, high again when count reaches 2.
- Assert reset during DATA bit 3 -> tx=1 next cycle, STATUS=0x1, DIV reads clock_rate.
